// File: rtl/pc_sequencer.sv
// ============================================================================
// pc_sequencer : instruction-fetch sequencer that owns the architectural PC,
//                issues req/ready fetches, buffers one word, resolves branches.
// Revision     : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_rdata,
    output logic        instr_valid,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    input  logic        br_valid,
    input  logic        br_is_reg,
    input  logic [2:0]  br_cond,
    input  logic [8:0]  br_imm,
    input  logic [15:0] br_pc,
    input  logic [15:0] br_reg,
    input  logic [2:0]  flags,
    input  logic        halt,
    output logic        flush,
    output logic        halted,
    output logic [15:0] pc
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FETCH  = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_HALTED = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] addr_q, addr_d;
    logic        pending_q, pending_d;
    logic        buf_valid_q, buf_valid_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] instr_pc_q, instr_pc_d;
    logic        drain_to_halt_q, drain_to_halt_d;

    logic        taken;
    logic [15:0] target;
    logic        redirect;
    logic        halt_go;

    always_comb begin
        taken = 1'b0;
        case (br_cond)
            3'b000:  taken = !flags[0];
            3'b001:  taken = flags[0];
            3'b010:  taken = !flags[0] && !flags[2];
            3'b011:  taken = flags[2];
            3'b100:  taken = flags[0] || !flags[2];
            3'b101:  taken = flags[2] || flags[0];
            3'b110:  taken = flags[1];
            default: taken = 1'b1;
        endcase
    end

    assign target = br_is_reg ? br_reg
                              : br_pc + 16'd2 + {{7{br_imm[8]}}, br_imm};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            pc_q            <= RESET_PC;
            addr_q          <= RESET_PC;
            pending_q       <= 1'b0;
            buf_valid_q     <= 1'b0;
            instr_q         <= 16'h0000;
            instr_pc_q      <= 16'h0000;
            drain_to_halt_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            addr_q          <= addr_d;
            pending_q       <= pending_d;
            buf_valid_q     <= buf_valid_d;
            instr_q         <= instr_d;
            instr_pc_q      <= instr_pc_d;
            drain_to_halt_q <= drain_to_halt_d;
        end
    end

    // A redirect or halt that catches an unfinished transfer must keep the
    // old request alive in DRAIN so the memory handshake is never abandoned.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        addr_d          = addr_q;
        pending_d       = pending_q;
        buf_valid_d     = buf_valid_q;
        instr_d         = instr_q;
        instr_pc_d      = instr_pc_q;
        drain_to_halt_d = drain_to_halt_q;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                addr_d = pc_q;
                if (redirect || halt_go) begin
                    buf_valid_d = 1'b0;
                    pending_d   = 1'b0;
                    if (redirect) pc_d = target;
                    if (imem_req && !imem_ready) begin
                        state_d         = S_DRAIN;
                        pending_d       = 1'b1;
                        drain_to_halt_d = halt_go;
                    end else if (halt_go) begin
                        state_d = S_HALTED;
                    end
                end else if (imem_req && imem_ready) begin
                    buf_valid_d = 1'b1;
                    instr_d     = imem_rdata;
                    instr_pc_d  = pc_q;
                    pc_d        = pc_q + 16'd2;
                    pending_d   = 1'b0;
                end else begin
                    if (imem_req) pending_d = 1'b1;
                    if (buf_valid_q && !stall) buf_valid_d = 1'b0;
                end
            end
            S_DRAIN: begin
                if (imem_ready) begin
                    pending_d = 1'b0;
                    state_d   = drain_to_halt_q ? S_HALTED : S_FETCH;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        imem_req  = 1'b0;
        imem_addr = (state_q == S_DRAIN) ? addr_q : pc_q;
        redirect  = 1'b0;
        halt_go   = 1'b0;
        if (state_q == S_FETCH) begin
            imem_req = pending_q || !buf_valid_q || !stall;
            redirect = br_valid && taken && !stall;
            halt_go  = halt && !br_valid && !stall;
        end else if (state_q == S_DRAIN) begin
            imem_req = 1'b1;
        end
        flush = redirect || halt_go;
    end

    assign instr_valid = buf_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign halted      = (state_q == S_HALTED);
    assign pc          = pc_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// tb_pc_sequencer : directed self-checking bench for pc_sequencer.
// Revision        : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        br_valid;
    logic        br_is_reg;
    logic [2:0]  br_cond;
    logic [8:0]  br_imm;
    logic [15:0] br_pc;
    logic [15:0] br_reg;
    logic [2:0]  flags;
    logic        halt;
    logic        flush;
    logic        halted;
    logic [15:0] pc;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .br_valid(br_valid), .br_is_reg(br_is_reg), .br_cond(br_cond),
        .br_imm(br_imm), .br_pc(br_pc), .br_reg(br_reg), .flags(flags),
        .halt(halt), .flush(flush), .halted(halted), .pc(pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory word is the address with the two top bits forced high.
    assign imem_rdata = imem_addr | 16'hC000;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_taken(input logic [2:0] c, input logic [2:0] f);
        logic n, v, z;
        n = f[2]; v = f[1]; z = f[0];
        case (c)
            3'd0:    return (z == 1'b0);
            3'd1:    return (z == 1'b1);
            3'd2:    return (z == 1'b0) && (n == 1'b0);
            3'd3:    return (n == 1'b1);
            3'd4:    return (z == 1'b1) || ((z == 1'b0) && (n == 1'b0));
            3'd5:    return (n == 1'b1) || (z == 1'b1);
            3'd6:    return (v == 1'b1);
            default: return 1'b1;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0; stall = 1'b0; imem_ready = 1'b1;
        br_valid = 1'b0; br_is_reg = 1'b0; br_cond = 3'd0; br_imm = 9'd0;
        br_pc = 16'h0000; br_reg = 16'h0000; flags = 3'd0; halt = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", imem_req, 16'd0);
        chk("rst_addr", imem_addr, 16'h0000);
        chk("rst_ivalid", instr_valid, 16'd0);
        chk("rst_instr", instr, 16'h0000);
        chk("rst_ipc", instr_pc, 16'h0000);
        chk("rst_flush", flush, 16'd0);
        chk("rst_halted", halted, 16'd0);
        chk("rst_pc", pc, 16'h0000);

        // Single-cycle memory streaming
        @(negedge clk); rst_n = 1'b1;
        tick(); #1;
        chk("first_req", imem_req, 16'd1);
        chk("first_addr", imem_addr, 16'h0000);
        chk("first_ivalid", instr_valid, 16'd0);
        tick(); #1;
        chk("seq_addr2", imem_addr, 16'h0002);
        chk("seq_ivalid", instr_valid, 16'd1);
        chk("seq_instr0", instr, 16'hC000);
        chk("seq_ipc0", instr_pc, 16'h0000);
        tick(); #1;
        chk("seq_addr4", imem_addr, 16'h0004);
        chk("seq_ipc2", instr_pc, 16'h0002);

        // 3-cycle latency with stall
        imem_ready = 1'b0; #1;
        chk("lat_req0", imem_req, 16'd1);
        chk("lat_addr0", imem_addr, 16'h0004);
        tick(); stall = 1'b1; #1;
        chk("lat_req1", imem_req, 16'd1);
        chk("lat_addr1", imem_addr, 16'h0004);
        chk("lat_ivalid1", instr_valid, 16'd0);
        tick(); imem_ready = 1'b1; #1;
        chk("lat_req2", imem_req, 16'd1);
        chk("lat_addr2", imem_addr, 16'h0004);
        tick(); imem_ready = 1'b0; #1;
        chk("lat_ivalid3", instr_valid, 16'd1);
        chk("lat_instr3", instr, 16'hC004);
        chk("lat_ipc3", instr_pc, 16'h0004);
        chk("lat_noreq3", imem_req, 16'd0);
        tick(); #1;
        chk("hold_ivalid", instr_valid, 16'd1);
        chk("hold_ipc", instr_pc, 16'h0004);
        stall = 1'b0; imem_ready = 1'b1; #1;
        chk("resume_req", imem_req, 16'd1);
        chk("resume_addr", imem_addr, 16'h0006);
        tick(); #1;
        chk("refill_ipc", instr_pc, 16'h0006);
        chk("refill_instr", instr, 16'hC006);
        chk("refill_addr", imem_addr, 16'h0008);

        // B cond 001, taken with Z=1: target 0010+2-16 = 0002
        br_valid = 1'b1; br_is_reg = 1'b0; br_cond = 3'b001; flags = 3'b001;
        br_pc = 16'h0010; br_imm = 9'h1F0; #1;
        chk("b_taken_flush", flush, 16'd1);
        tick(); br_valid = 1'b0; #1;
        chk("b_after_flush", flush, 16'd0);
        chk("b_after_ivalid", instr_valid, 16'd0);
        chk("b_target_addr", imem_addr, 16'h0002);
        tick(); flags = 3'b000; br_valid = 1'b1; #1;
        chk("b_nt_flush", flush, 16'd0);
        chk("b_tgt_ipc", instr_pc, 16'h0002);
        chk("b_nt_addr", imem_addr, 16'h0004);
        tick(); br_valid = 1'b0; #1;
        chk("b_nt_seq_addr", imem_addr, 16'h0006);
        chk("b_nt_seq_ipc", instr_pc, 16'h0004);
        chk("b_nt_pc", pc, 16'h0006);

        // BR while a request is pending: drain then fetch 1234
        imem_ready = 1'b0; #1;
        tick();
        br_valid = 1'b1; br_is_reg = 1'b1; br_cond = 3'b111; br_reg = 16'h1234; #1;
        chk("br_flush", flush, 16'd1);
        tick(); br_valid = 1'b0; imem_ready = 1'b1; #1;
        chk("drain_req", imem_req, 16'd1);
        chk("drain_addr", imem_addr, 16'h0006);
        chk("drain_ivalid", instr_valid, 16'd0);
        chk("drain_pc", pc, 16'h1234);
        tick(); #1;
        chk("br_tgt_req", imem_req, 16'd1);
        chk("br_tgt_addr", imem_addr, 16'h1234);
        chk("br_discard", instr_valid, 16'd0);
        tick(); #1;
        chk("br_tgt_instr", instr, 16'hD234);
        chk("br_tgt_ipc", instr_pc, 16'h1234);
        chk("br_tgt_ivalid", instr_valid, 16'd1);

        // Condition walk
        br_valid = 1'b1; br_is_reg = 1'b1; br_reg = 16'h0100;
        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 8; f++) begin
                br_cond = c[2:0]; flags = f[2:0]; #1;
                chk($sformatf("cond%0d_flags%0d", c, f), flush, {15'd0, exp_taken(c[2:0], f[2:0])});
                tick();
            end
        end
        br_valid = 1'b0; #1;
        chk("walk_end_addr", imem_addr, 16'h0100);

        // Halt with a pending fetch
        imem_ready = 1'b0; #1;
        tick(); halt = 1'b1; #1;
        chk("halt_flush", flush, 16'd1);
        tick(); halt = 1'b0; imem_ready = 1'b1; #1;
        chk("hdrain_req", imem_req, 16'd1);
        chk("hdrain_addr", imem_addr, 16'h0100);
        chk("hdrain_halted", halted, 16'd0);
        chk("hdrain_ivalid", instr_valid, 16'd0);
        tick(); #1;
        chk("halted_flag", halted, 16'd1);
        chk("halted_req", imem_req, 16'd0);
        chk("halted_ivalid", instr_valid, 16'd0);
        chk("halted_pc", pc, 16'h0100);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("halted_stay_req", imem_req, 16'd0);
            chk("halted_stay", halted, 16'd1);
        end

        // Async reset out of HALTED
        #1 rst_n = 1'b0; #1;
        chk("areset_pc", pc, 16'h0000);
        chk("areset_halted", halted, 16'd0);
        chk("areset_req", imem_req, 16'd0);
        chk("areset_addr", imem_addr, 16'h0000);
        @(negedge clk); rst_n = 1'b1;
        tick(); #1;
        chk("rerun_req", imem_req, 16'd1);
        chk("rerun_addr", imem_addr, 16'h0000);

        // PC wrap FFFE -> 0000
        br_valid = 1'b1; br_is_reg = 1'b1; br_cond = 3'b111; br_reg = 16'hFFFE; #1;
        chk("wrap_flush", flush, 16'd1);
        tick(); br_valid = 1'b0; #1;
        chk("wrap_addr_fffe", imem_addr, 16'hFFFE);
        tick(); #1;
        chk("wrap_addr_0", imem_addr, 16'h0000);
        chk("wrap_ipc", instr_pc, 16'hFFFE);
        chk("wrap_pc", pc, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
